// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - shared state encoding and default timings for the 1-wire cores
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    SLOT_END,
    RST_WAIT,
    PRES_WAIT,
    PRES
  } state_t;

  localparam int TW        = 16;
  localparam int T_RSTL_US = 400;
  localparam int T_PDH_US  = 30;
  localparam int T_PDL_US  = 120;
  localparam int T_SMP_US  = 30;

endpackage

// File: rtl/onewire_sync.sv
// rtl/onewire_sync.sv - 2-flop synchronizer with edge detect for the raw 1-wire level
module onewire_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  // sr[1:0] synchronize, sr[2] holds the previous synced level; idle bus is high
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= 3'b111;
    else        sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign fall  = sr[2] & ~sr[1];
  assign rise  = ~sr[2] & sr[1];

endmodule

// File: rtl/onewire_slave.sv
// rtl/onewire_slave.sv - 1-wire device responder: reset/presence, write and read slots
// Optional overdrive timing select via ONEWIRE_SLAVE_OVD_EN.
module onewire_slave #(
  parameter int CLK_MHZ = 32,
  parameter int T_RSTL  = onewire_pkg::T_RSTL_US * CLK_MHZ,
  parameter int T_PDH   = onewire_pkg::T_PDH_US * CLK_MHZ,
  parameter int T_PDL   = onewire_pkg::T_PDL_US * CLK_MHZ,
  parameter int T_SMP   = onewire_pkg::T_SMP_US * CLK_MHZ,
  parameter int TW      = onewire_pkg::TW
) (
`ifdef ONEWIRE_SLAVE_OVD_EN
  input  logic       ovd,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       owr_i,
  output logic       owr_e,
  output logic       rst_det,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic [7:0] tx_data,
  input  logic       tx_ld,
  output logic       tx_busy
);
  import onewire_pkg::*;

  state_t        state, state_n;
  logic          level, fall, rise;
  logic [TW-1:0] lcnt, stmr;
  logic [TW-1:0] t_rstl, t_pdh, t_pdl, t_smp;
  logic [7:0]    rx_sr, tx_sr, rx_nxt;
  logic [2:0]    bitcnt;
  logic          rst_arm, rst_hit, tx_acc, sample;

  onewire_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (owr_i),
    .level (level),
    .fall  (fall),
    .rise  (rise)
  );

`ifdef ONEWIRE_SLAVE_OVD_EN
  logic ovd_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   ovd_r <= 1'b0;
    else if (state == IDLE || state == RST_WAIT)  ovd_r <= ovd;
  end

  assign t_rstl = ovd_r ? TW'(T_RSTL >> 3) : TW'(T_RSTL);
  assign t_pdh  = ovd_r ? TW'(T_PDH >> 3)  : TW'(T_PDH);
  assign t_pdl  = ovd_r ? TW'(T_PDL >> 3)  : TW'(T_PDL);
  assign t_smp  = ovd_r ? TW'(T_SMP >> 3)  : TW'(T_SMP);
`else
  assign t_rstl = TW'(T_RSTL);
  assign t_pdh  = TW'(T_PDH);
  assign t_pdl  = TW'(T_PDL);
  assign t_smp  = TW'(T_SMP);
`endif

  // rst_arm keeps a long low from reporting more than one reset
  assign rst_hit = rst_arm && (lcnt == t_rstl);
  assign tx_acc  = tx_ld && !tx_busy && (state != SLOT) && !rst_hit;
  assign sample  = (state == SLOT) && (stmr == t_smp);
  assign rx_nxt  = {level, rx_sr[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (rst_hit) begin
      state_n = RST_WAIT;
    end else begin
      case (state)
        IDLE:      if (fall) state_n = SLOT;
        SLOT:      if (stmr == t_smp) state_n = SLOT_END;
        SLOT_END:  if (level) state_n = IDLE;
        RST_WAIT:  if (level) state_n = PRES_WAIT;
        PRES_WAIT: if (fall) state_n = SLOT;
                   else if (stmr == t_pdh) state_n = PRES;
        PRES:      if (stmr == t_pdl - 1'b1) state_n = SLOT_END;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    owr_e = 1'b0;
    if (!rst_hit) begin
      if (state == PRES) owr_e = 1'b1;
      else if (state == SLOT && tx_busy && !tx_sr[bitcnt] && stmr < t_smp) owr_e = 1'b1;
    end
  end

  // slot timer restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stmr    <= '0;
      lcnt    <= '0;
      rst_arm <= 1'b1;
    end else begin
      stmr <= (state_n != state) ? '0 : stmr + 1'b1;
      if (level || owr_e)  lcnt <= '0;
      else if (lcnt != '1) lcnt <= lcnt + 1'b1;
      if (rst_hit)   rst_arm <= 1'b0;
      else if (rise) rst_arm <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_det <= 1'b0;
      rx_vld  <= 1'b0;
      rx_data <= 8'h00;
      rx_sr   <= 8'h00;
      tx_sr   <= 8'h00;
      tx_busy <= 1'b0;
      bitcnt  <= 3'd0;
    end else begin
      rst_det <= rst_hit;
      rx_vld  <= 1'b0;
      if (rst_hit) begin
        bitcnt  <= 3'd0;
        rx_sr   <= 8'h00;
        tx_busy <= 1'b0;
      end else if (tx_acc) begin
        tx_sr   <= tx_data;
        tx_busy <= 1'b1;
        bitcnt  <= 3'd0;
      end else if (sample) begin
        rx_sr  <= rx_nxt;
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          rx_data <= rx_nxt;
          rx_vld  <= 1'b1;
          tx_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_onewire_slave.sv
// tb/tb_onewire_slave.sv - scoreboard bench for onewire_slave with a wired-AND bus model
module tb_onewire_slave;

  localparam int CLK_MHZ = 32;
  localparam int T_RSTL  = 400 * CLK_MHZ;
  localparam int T_PDH   = 30 * CLK_MHZ;
  localparam int T_PDL   = 120 * CLK_MHZ;
  localparam int T_SMP   = 30 * CLK_MHZ;
  // two synchronizer flops plus one registered stage before the observed output
  localparam int LAT_DET  = 3;
  localparam int LAT_PRES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mlow = 1'b0;
  logic       tx_ld = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       owr_i, owr_e, rst_det, rx_vld, tx_busy;
  logic [7:0] rx_data;
`ifdef ONEWIRE_SLAVE_OVD_EN
  logic       ovd = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         fell_q[$];
  logic       busy_d = 1'b0;

  assign owr_i = ~(mlow | owr_e);

  always #5 clk = ~clk;

  onewire_slave dut (
`ifdef ONEWIRE_SLAVE_OVD_EN
    .ovd     (ovd),
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .owr_i   (owr_i),
    .owr_e   (owr_e),
    .rst_det (rst_det),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .tx_data (tx_data),
    .tx_ld   (tx_ld),
    .tx_busy (tx_busy)
  );

  always @(negedge clk) begin
    if (rx_vld) begin
      got_q.push_back(rx_data);
      fell_q.push_back(busy_d & ~tx_busy);
    end
    busy_d = tx_busy;
  end

  task automatic bus_reset(input int low_cyc, input int win, output int det_at, output int npulse,
                           output int pres_at, output int pres_len);
    det_at = -1; npulse = 0; pres_at = -1; pres_len = 0;
    @(negedge clk);
    mlow = 1'b1;
    for (int i = 1; i <= low_cyc; i++) begin
      @(negedge clk);
      if (rst_det) begin
        npulse++;
        if (det_at < 0) det_at = i;
      end
    end
    mlow = 1'b0;
    for (int j = 1; j <= win; j++) begin
      @(negedge clk);
      if (owr_e) begin
        pres_len++;
        if (pres_at < 0) pres_at = j;
      end
    end
  endtask

  task automatic do_slot(input int low_cyc, output bit rd, output int drv);
    int len;
    len = (low_cyc > T_SMP) ? low_cyc + 64 : T_SMP + 140;
    rd = 1'b1; drv = 0;
    @(negedge clk);
    mlow = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == low_cyc) mlow = 1'b0;
      if (i == 480) rd = owr_i;
      if (owr_e) drv++;
    end
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_ld = 1'b1;
    @(negedge clk);
    tx_ld = 1'b0;
  endtask

  task automatic test_reset;
    int det_at, np, pat, plen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (owr_e !== 1'b0) $display("FAIL reset_owr_e: got %b expected 0", owr_e); else passed++;
    total++; if (rst_det !== 1'b0) $display("FAIL reset_rst_det: got %b expected 0", rst_det); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
    total++; if (rx_vld !== 1'b0) $display("FAIL reset_rx_vld: got %b expected 0", rx_vld); else passed++;
    total++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    got_q.delete(); fell_q.delete();
    bus_reset(480 * CLK_MHZ, T_PDH + T_PDL + 200, det_at, np, pat, plen);
    total++; if (det_at !== T_RSTL + LAT_DET) $display("FAIL rst_det_time: got %0d expected %0d", det_at, T_RSTL + LAT_DET); else passed++;
    total++; if (np !== 1) $display("FAIL rst_det_pulses: got %0d expected 1", np); else passed++;
    total++; if (pat !== T_PDH + LAT_PRES) $display("FAIL pres_start: got %0d expected %0d", pat, T_PDH + LAT_PRES); else passed++;
    total++; if (plen !== T_PDL) $display("FAIL pres_len: got %0d expected %0d", plen, T_PDL); else passed++;
    total++; if (got_q.size() !== 0) $display("FAIL reset_no_rx: got %0d expected 0", got_q.size()); else passed++;
  endtask

  task automatic test_write;
    logic [7:0] b, e, g;
    bit rd, f;
    int drv;
    b = 8'hA5;
    got_q.delete(); fell_q.delete();
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) do_slot(b[i] ? 6 * CLK_MHZ : 60 * CLK_MHZ, rd, drv);
    e = exp_q.pop_front();
    total++; if (got_q.size() !== 1) $display("FAIL write_rx_count: got %0d expected 1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      g = got_q.pop_front(); f = fell_q.pop_front();
      total++; if (g !== e) $display("FAIL write_rx_data: got %h expected %h", g, e); else passed++;
      total++; if (f !== 1'b0) $display("FAIL write_busy_fell: got %b expected 0", f); else passed++;
    end
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic [7:0] second, input bit use_second);
    logic [7:0] rb, e, g;
    bit rd, f;
    int drv;
    got_q.delete(); fell_q.delete();
    load(b);
    total++; if (tx_busy !== 1'b1) $display("FAIL tx_busy_set: got %b expected 1", tx_busy); else passed++;
    if (use_second) load(second);
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
      do_slot(2 * CLK_MHZ, rd, drv);
      rb[i] = rd;
      total++;
      if (drv !== (b[i] ? 0 : T_SMP)) $display("FAIL tx_drive_len bit%0d: got %0d expected %0d", i, drv, b[i] ? 0 : T_SMP);
      else passed++;
    end
    total++; if (rb !== b) $display("FAIL tx_readback: got %h expected %h", rb, b); else passed++;
    total++; if (tx_busy !== 1'b0) $display("FAIL tx_busy_clear: got %b expected 0", tx_busy); else passed++;
    e = exp_q.pop_front();
    total++; if (got_q.size() !== 1) $display("FAIL tx_rx_count: got %0d expected 1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      g = got_q.pop_front(); f = fell_q.pop_front();
      total++; if (g !== e) $display("FAIL tx_rx_data: got %h expected %h", g, e); else passed++;
      total++; if (f !== 1'b1) $display("FAIL tx_busy_with_vld: got %b expected 1", f); else passed++;
    end
  endtask

  task automatic test_tx;
    tx_byte(8'h3C, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    tx_byte(8'h96, 8'h0F, 1'b1);
  endtask

  task automatic test_reset_mid_tx;
    int det_at, np, pat, plen, drv;
    bit rd;
    got_q.delete(); fell_q.delete();
    load(8'h3C);
    for (int i = 0; i < 4; i++) do_slot(2 * CLK_MHZ, rd, drv);
    bus_reset(480 * CLK_MHZ, T_PDH + T_PDL + 200, det_at, np, pat, plen);
    total++; if (det_at !== T_RSTL + LAT_DET) $display("FAIL mid_rst_det_time: got %0d expected %0d", det_at, T_RSTL + LAT_DET); else passed++;
    total++; if (np !== 1) $display("FAIL mid_rst_pulses: got %0d expected 1", np); else passed++;
    total++; if (tx_busy !== 1'b0) $display("FAIL mid_tx_busy: got %b expected 0", tx_busy); else passed++;
    total++; if (plen !== T_PDL) $display("FAIL mid_pres_len: got %0d expected %0d", plen, T_PDL); else passed++;
    total++; if (got_q.size() !== 0) $display("FAIL mid_no_rx_vld: got %0d expected 0", got_q.size()); else passed++;
  endtask

`ifdef ONEWIRE_SLAVE_OVD_EN
  task automatic test_ovd;
    int det_at, np, pat, plen;
    ovd = 1'b1;
    repeat (4) @(negedge clk);
    bus_reset(60 * CLK_MHZ, (T_PDH >> 3) + (T_PDL >> 3) + 100, det_at, np, pat, plen);
    total++; if (det_at !== (T_RSTL >> 3) + LAT_DET) $display("FAIL ovd_rst_det_time: got %0d expected %0d", det_at, (T_RSTL >> 3) + LAT_DET); else passed++;
    total++; if (pat !== (T_PDH >> 3) + LAT_PRES) $display("FAIL ovd_pres_start: got %0d expected %0d", pat, (T_PDH >> 3) + LAT_PRES); else passed++;
    total++; if (plen !== (T_PDL >> 3)) $display("FAIL ovd_pres_len: got %0d expected %0d", plen, T_PDL >> 3); else passed++;
    ovd = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_tx;
    test_back_to_back;
    test_reset_mid_tx;
`ifdef ONEWIRE_SLAVE_OVD_EN
    test_ovd;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
